// File: rtl/redirect_program_counter.sv
// Fetch program counter with prioritised redirect channels.
// Tracks PC-change sequence and redirect epoch counters alongside the presented PC.
module redirect_program_counter #(
  parameter int                XLEN         = 32,
  parameter logic [XLEN-1:0]   RESET_VECTOR = 32'h00003000,
  parameter int                STEP         = 4,
  parameter int                NUM_REDIRECT = 2,
  parameter int                SEQ_WIDTH    = 1,
  parameter int                EPOCH_WIDTH  = 2
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                fetchReady,
  input  logic [NUM_REDIRECT-1:0]             redirectValid,
  input  logic [NUM_REDIRECT-1:0][XLEN-1:0]   redirectTarget,
  output logic [XLEN-1:0]                     pc,
  output logic                                pcValid,
  output logic [SEQ_WIDTH-1:0]                seq,
  output logic [EPOCH_WIDTH-1:0]              epoch,
  output logic                                misaligned
);

  localparam logic [XLEN-1:0] STEP_INC   = XLEN'(STEP);
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(STEP - 1);

  typedef enum logic {
    STATE_RESET = 1'b0,
    STATE_RUN   = 1'b1
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [XLEN-1:0]        pc_next;
  logic [SEQ_WIDTH-1:0]   seq_next;
  logic [EPOCH_WIDTH-1:0] epoch_next;
  logic                   misaligned_next;
  logic                   redirect_hit;
  logic [XLEN-1:0]        redirect_sel;
  logic                   accept;

  // Scanning downwards lets the lowest requesting channel overwrite the others.
  always_comb begin
    redirect_hit = 1'b0;
    redirect_sel = '0;
    for (int i = NUM_REDIRECT - 1; i >= 0; i--) begin
      if (redirectValid[i]) begin
        redirect_hit = 1'b1;
        redirect_sel = redirectTarget[i];
      end
    end
  end

  assign accept = pcValid && fetchReady;

  always_comb begin
    state_next      = state;
    pc_next         = pc;
    seq_next        = seq;
    epoch_next      = epoch;
    misaligned_next = misaligned;
    case (state)
      STATE_RESET: begin
        state_next = STATE_RUN;
      end
      STATE_RUN: begin
        if (redirect_hit) begin
          pc_next         = redirect_sel & ~ALIGN_MASK;
          misaligned_next = |(redirect_sel & ALIGN_MASK);
          epoch_next      = epoch + EPOCH_WIDTH'(1);
          seq_next        = seq + SEQ_WIDTH'(1);
        end else if (accept) begin
          pc_next         = pc + STEP_INC;
          misaligned_next = 1'b0;
          seq_next        = seq + SEQ_WIDTH'(1);
        end
      end
      default: begin
        state_next = STATE_RESET;
      end
    endcase
  end

  // pcValid is registered from the next state so it rises together with the RUN entry.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= STATE_RESET;
      pc         <= RESET_VECTOR;
      pcValid    <= 1'b0;
      seq        <= '0;
      epoch      <= '0;
      misaligned <= 1'b0;
    end else begin
      state      <= state_next;
      pc         <= pc_next;
      pcValid    <= (state_next == STATE_RUN);
      seq        <= seq_next;
      epoch      <= epoch_next;
      misaligned <= misaligned_next;
    end
  end

endmodule
